lockstep_miter: RTL and testbench

Sequential, parametrised equivalence monitor comparing a gold (reference) and a gate (implementation) stream of LANES×WIDTH-bit words, cycle-by-cycle, in simulation and on FPGA prototypes of aes_cipher_top. It generalises the single-bit combinational output compare used by the equivalence flow in three ways: multi-lane, per-bit don't-care masking, and latency tolerance through an alignment FIFO. It also keeps sticky failure statistics. It sits beside the DUT pair and drives only status outputs.

---
 rtl/lockstep_miter.sv | 170 +++++++++++++++++
 tb/tb_lockstep_miter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_miter.sv
// lockstep_miter: cycle-by-cycle gold/gate equivalence monitor with per-bit
// don't-care masking, a latency-absorbing alignment FIFO and sticky statistics.
module lockstep_miter #(
    parameter  int unsigned WIDTH        = 8,
    parameter  int unsigned LANES        = 4,
    parameter  int unsigned DEPTH        = 8,
    parameter  int unsigned CNT_W        = 16,
    parameter  bit          STOP_ON_FAIL = 1'b1,
    localparam int unsigned LW           = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   clear,
    input  logic                   gold_valid,
    input  logic [LANES*WIDTH-1:0] gold_data,
    input  logic [LANES*WIDTH-1:0] gold_care,
    input  logic                   gate_valid,
    input  logic [LANES*WIDTH-1:0] gate_data,
    output logic                   busy,
    output logic                   halted,
    output logic                   fail,
    output logic [LANES-1:0]       fail_lane,
    output logic                   align_err,
    output logic [CNT_W-1:0]       sample_cnt,
    output logic [CNT_W-1:0]       mismatch_cnt,
    output logic [CNT_W-1:0]       first_idx,
    output logic [LW-1:0]          first_lane,
    output logic [WIDTH-1:0]       first_gold,
    output logic [WIDTH-1:0]       first_gate
);

    localparam int unsigned DW = LANES * WIDTH;
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    state_t           state;
    state_t           next_state;
    logic [DW-1:0]    mem_data [DEPTH];
    logic [DW-1:0]    mem_care [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic             in_run;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             do_cmp;
    logic             any_fail;
    logic             align_hit;
    logic [DW-1:0]    cmp_gold;
    logic [DW-1:0]    cmp_care;
    logic [DW-1:0]    mism;
    logic [LANES-1:0] lane_fail;
    logic [LW-1:0]    fl_idx;
    logic [WIDTH-1:0] fl_gold;
    logic [WIDTH-1:0] fl_gate;

    // FIFO control, bypass selection, masked compare and lowest failing lane
    always_comb begin
        in_run     = (state == RUN) && !clear;
        fifo_empty = (count == '0);
        fifo_full  = (count == (AW+1)'(DEPTH));
        // Empty FIFO with both valids compares the incoming gold word directly
        do_cmp     = in_run && gate_valid && (!fifo_empty || gold_valid);
        pop        = in_run && gate_valid && !fifo_empty;
        push       = in_run && gold_valid && !(fifo_empty && gate_valid)
                     && (!fifo_full || gate_valid);
        align_hit  = in_run && ((gate_valid && fifo_empty && !gold_valid)
                     || (gold_valid && fifo_full && !gate_valid));
        cmp_gold   = fifo_empty ? gold_data : mem_data[rd_ptr];
        cmp_care   = fifo_empty ? gold_care : mem_care[rd_ptr];
        mism       = cmp_care & (cmp_gold ^ gate_data);
        lane_fail  = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            lane_fail[i] = |mism[i*WIDTH +: WIDTH];
        end
        any_fail = do_cmp && (lane_fail != '0);
        fl_idx   = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (lane_fail[i]) fl_idx = LW'(i);
        end
        fl_gold = cmp_gold[fl_idx*WIDTH +: WIDTH];
        fl_gate = gate_data[fl_idx*WIDTH +: WIDTH];
    end

    // Session state transitions (clear priority is applied in the register)
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (any_fail && STOP_ON_FAIL) next_state = HALT;
            default: next_state = state;
        endcase
    end

    // Alignment FIFO storage; no reset needed since occupancy guards reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= gold_data;
            mem_care[wr_ptr] <= gold_care;
        end
    end

    // State, FIFO pointers and sticky statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            halted       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fail         <= 1'b0;
            fail_lane    <= '0;
            align_err    <= 1'b0;
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            first_idx    <= '0;
            first_lane   <= '0;
            first_gold   <= '0;
            first_gate   <= '0;
        end else if (clear) begin
            state        <= IDLE;
            busy         <= 1'b0;
            halted       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fail         <= 1'b0;
            fail_lane    <= '0;
            align_err    <= 1'b0;
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            first_idx    <= '0;
            first_lane   <= '0;
            first_gold   <= '0;
            first_gate   <= '0;
        end else begin
            state  <= next_state;
            busy   <= (next_state == RUN);
            halted <= (next_state == HALT);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
            if (align_hit) align_err <= 1'b1;
            if (do_cmp && (sample_cnt != {CNT_W{1'b1}})) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
            if (any_fail) begin
                if (mismatch_cnt != {CNT_W{1'b1}}) begin
                    mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                end
                fail_lane <= fail_lane | lane_fail;
                if (!fail) begin
                    fail       <= 1'b1;
                    first_idx  <= sample_cnt;
                    first_lane <= fl_idx;
                    first_gold <= fl_gold;
                    first_gate <= fl_gate;
                end
            end
        end
    end

endmodule

// File: tb/tb_lockstep_miter.sv
// Scoreboard bench for lockstep_miter: a halting instance (u0) and a running,
// 4-bit-counter instance (u1) share stimulus; expected values are queued by
// the stimulus and checked by an independent monitor on the falling edge.
module tb_lockstep_miter;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic          clear;
    logic          gold_valid;
    logic [DW-1:0] gold_data;
    logic [DW-1:0] gold_care;
    logic          gate_valid;
    logic [DW-1:0] gate_data;

    logic          u0_busy, u0_halted, u0_fail, u0_align_err;
    logic [3:0]    u0_fail_lane;
    logic [15:0]   u0_sample_cnt, u0_mismatch_cnt, u0_first_idx;
    logic [1:0]    u0_first_lane;
    logic [7:0]    u0_first_gold, u0_first_gate;

    logic          u1_busy, u1_halted, u1_fail, u1_align_err;
    logic [3:0]    u1_fail_lane;
    logic [3:0]    u1_sample_cnt, u1_mismatch_cnt, u1_first_idx;
    logic [1:0]    u1_first_lane;
    logic [7:0]    u1_first_gold, u1_first_gate;

    lockstep_miter u0 (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .gold_valid(gold_valid), .gold_data(gold_data), .gold_care(gold_care),
        .gate_valid(gate_valid), .gate_data(gate_data),
        .busy(u0_busy), .halted(u0_halted), .fail(u0_fail),
        .fail_lane(u0_fail_lane), .align_err(u0_align_err),
        .sample_cnt(u0_sample_cnt), .mismatch_cnt(u0_mismatch_cnt),
        .first_idx(u0_first_idx), .first_lane(u0_first_lane),
        .first_gold(u0_first_gold), .first_gate(u0_first_gate)
    );

    lockstep_miter #(.CNT_W(4), .STOP_ON_FAIL(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .gold_valid(gold_valid), .gold_data(gold_data), .gold_care(gold_care),
        .gate_valid(gate_valid), .gate_data(gate_data),
        .busy(u1_busy), .halted(u1_halted), .fail(u1_fail),
        .fail_lane(u1_fail_lane), .align_err(u1_align_err),
        .sample_cnt(u1_sample_cnt), .mismatch_cnt(u1_mismatch_cnt),
        .first_idx(u1_first_idx), .first_lane(u1_first_lane),
        .first_gold(u1_first_gold), .first_gate(u1_first_gate)
    );

    // Field selectors: instance offset plus field number
    localparam int U0 = 0, U1 = 16;
    localparam int F_BUSY = 0, F_HALT = 1, F_FAIL = 2, F_LANE = 3, F_ALIGN = 4,
                   F_SAMP = 5, F_MISM = 6, F_FIDX = 7, F_FLANE = 8,
                   F_FGOLD = 9, F_FGATE = 10;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            U0 + F_BUSY:  return 32'(u0_busy);
            U0 + F_HALT:  return 32'(u0_halted);
            U0 + F_FAIL:  return 32'(u0_fail);
            U0 + F_LANE:  return 32'(u0_fail_lane);
            U0 + F_ALIGN: return 32'(u0_align_err);
            U0 + F_SAMP:  return 32'(u0_sample_cnt);
            U0 + F_MISM:  return 32'(u0_mismatch_cnt);
            U0 + F_FIDX:  return 32'(u0_first_idx);
            U0 + F_FLANE: return 32'(u0_first_lane);
            U0 + F_FGOLD: return 32'(u0_first_gold);
            U0 + F_FGATE: return 32'(u0_first_gate);
            U1 + F_BUSY:  return 32'(u1_busy);
            U1 + F_HALT:  return 32'(u1_halted);
            U1 + F_FAIL:  return 32'(u1_fail);
            U1 + F_LANE:  return 32'(u1_fail_lane);
            U1 + F_ALIGN: return 32'(u1_align_err);
            U1 + F_SAMP:  return 32'(u1_sample_cnt);
            U1 + F_MISM:  return 32'(u1_mismatch_cnt);
            U1 + F_FIDX:  return 32'(u1_first_idx);
            default:      return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        q.push_back(c);
    endtask

    // Monitor: drains queued expectations against the DUT on each falling edge
    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                c   = q.pop_front();
                act = actual(c.sel);
                n_chk++;
                if (act === c.exp) n_pass++;
                else $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start      = 1'b0;
        clear      = 1'b0;
        gold_valid = 1'b0;
        gate_valid = 1'b0;
        gold_data  = '0;
        gold_care  = '1;
        gate_data  = '0;
    endtask

    task automatic new_session();
        quiet();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    function automatic logic [31:0] gword(input int k);
        return 32'h1122_3344 + 32'(k) * 32'h0101_0101;
    endfunction

    initial begin
        logic [31:0] w;
        logic [31:0] diff;

        quiet();
        rst = 1'b0;
        // Reset state
        expect_val("rst_busy",   U0 + F_BUSY, 0);
        expect_val("rst_halt",   U0 + F_HALT, 0);
        expect_val("rst_fail",   U0 + F_FAIL, 0);
        expect_val("rst_align",  U0 + F_ALIGN, 0);
        expect_val("rst_samp",   U0 + F_SAMP, 0);
        expect_val("rst_fgold",  U0 + F_FGOLD, 0);
        #22;
        rst = 1'b1;

        // Lockstep pass: 100 equal random words through the bypass path
        new_session();
        for (int k = 0; k < 100; k++) begin
            w = $urandom;
            gold_valid = 1'b1; gate_valid = 1'b1;
            gold_data = w; gate_data = w; gold_care = '1;
            cyc();
        end
        quiet();
        expect_val("lock_samp",    U0 + F_SAMP, 100);
        expect_val("lock_mism",    U0 + F_MISM, 0);
        expect_val("lock_fail",    U0 + F_FAIL, 0);
        expect_val("lock_busy",    U0 + F_BUSY, 1);
        expect_val("lock_u1_samp", U1 + F_SAMP, 15);

        // Latency 3, sample 5 has lane 2 bit 0 flipped
        new_session();
        for (int c = 0; c < 13; c++) begin
            gold_valid = 1'b1;
            gold_data  = gword(c);
            gold_care  = '1;
            gate_valid = (c >= 3);
            gate_data  = (c >= 3) ? gword(c - 3) : '0;
            if (c == 8) gate_data = gate_data ^ 32'h0001_0000;
            cyc();
        end
        quiet();
        expect_val("lat_fail",  U0 + F_FAIL, 1);
        expect_val("lat_lane",  U0 + F_LANE, 4'b0100);
        expect_val("lat_fidx",  U0 + F_FIDX, 5);
        expect_val("lat_flane", U0 + F_FLANE, 2);
        expect_val("lat_fgold", U0 + F_FGOLD, 8'h27);
        expect_val("lat_fgate", U0 + F_FGATE, 8'h26);
        expect_val("lat_halt",  U0 + F_HALT, 1);
        expect_val("lat_busy",  U0 + F_BUSY, 0);
        expect_val("lat_samp",  U0 + F_SAMP, 6);
        expect_val("lat_mism",  U0 + F_MISM, 1);

        // Don't-care masking: every differing bit has care=0
        new_session();
        for (int k = 0; k < 50; k++) begin
            w    = $urandom;
            diff = 32'h0101_0101 << (k % 8);
            gold_valid = 1'b1; gate_valid = 1'b1;
            gold_data = w; gate_data = w ^ diff; gold_care = ~diff;
            cyc();
        end
        quiet();
        expect_val("mask_mism",    U0 + F_MISM, 0);
        expect_val("mask_samp",    U0 + F_SAMP, 50);
        expect_val("mask_fail",    U0 + F_FAIL, 0);
        expect_val("mask_u1_mism", U1 + F_MISM, 0);

        // Overflow: 9 gold words into an 8-deep FIFO, then drain with gate words
        new_session();
        for (int k = 0; k < 9; k++) begin
            gold_valid = 1'b1;
            gold_data  = 32'hA0A0_A0A0 + 32'(k);
            cyc();
        end
        quiet();
        expect_val("ovf_align", U0 + F_ALIGN, 1);
        expect_val("ovf_samp0", U0 + F_SAMP, 0);
        for (int k = 0; k < 9; k++) begin
            gate_valid = 1'b1;
            gate_data  = 32'hA0A0_A0A0 + 32'(k);
            cyc();
        end
        quiet();
        expect_val("ovf_samp8", U0 + F_SAMP, 8);
        expect_val("ovf_mism",  U0 + F_MISM, 0);
        expect_val("ovf_fail",  U0 + F_FAIL, 0);

        // Gate word with an empty FIFO and no gold word
        new_session();
        expect_val("empty_align0", U0 + F_ALIGN, 0);
        gate_valid = 1'b1;
        gate_data  = 32'h1234_5678;
        cyc();
        quiet();
        expect_val("empty_align1", U0 + F_ALIGN, 1);
        expect_val("empty_samp",   U0 + F_SAMP, 0);
        expect_val("empty_busy",   U0 + F_BUSY, 1);

        // Running mode saturation on u1; u0 halts after the first compare
        new_session();
        for (int k = 0; k < 20; k++) begin
            w = $urandom;
            gold_valid = 1'b1; gate_valid = 1'b1;
            gold_data = w; gate_data = ~w; gold_care = '1;
            cyc();
        end
        quiet();
        expect_val("sat_mism",    U1 + F_MISM, 15);
        expect_val("sat_samp",    U1 + F_SAMP, 15);
        expect_val("sat_fidx",    U1 + F_FIDX, 0);
        expect_val("sat_busy",    U1 + F_BUSY, 1);
        expect_val("sat_lane",    U1 + F_LANE, 4'hF);
        expect_val("sat_u0_samp", U0 + F_SAMP, 1);
        expect_val("sat_u0_halt", U0 + F_HALT, 1);

        // Reset mid-session, observed before any further rising edge
        new_session();
        for (int k = 0; k < 2; k++) begin
            gold_valid = 1'b1; gate_valid = 1'b1;
            gold_data = 32'h5555_5555; gate_data = 32'hAAAA_AAAA; gold_care = '1;
            cyc();
        end
        quiet();
        expect_val("pre_u1_samp", U1 + F_SAMP, 2);
        expect_val("pre_u0_fail", U0 + F_FAIL, 1);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        expect_val("mrst_u0_halt",  U0 + F_HALT, 0);
        expect_val("mrst_u0_fail",  U0 + F_FAIL, 0);
        expect_val("mrst_u0_fgold", U0 + F_FGOLD, 0);
        expect_val("mrst_u0_mism",  U0 + F_MISM, 0);
        expect_val("mrst_u1_busy",  U1 + F_BUSY, 0);
        expect_val("mrst_u1_samp",  U1 + F_SAMP, 0);
        #5;
        rst = 1'b1;

        // clear and start together: clear wins, then start alone arms
        clear = 1'b1;
        start = 1'b1;
        cyc();
        quiet();
        expect_val("clrst_u0_busy", U0 + F_BUSY, 0);
        expect_val("clrst_u1_busy", U1 + F_BUSY, 0);
        start = 1'b1;
        cyc();
        quiet();
        expect_val("arm_u0_busy", U0 + F_BUSY, 1);

        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
